// File: rtl/tlul_pkg.sv
// Purpose: shared TL-UL opcode enums, field widths and the byte-lane helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package tlul_pkg;

   localparam int TL_DW  = 32;  // data width
   localparam int TL_AIW = 3;   // source id width
   localparam int TL_DIW = 2;   // sink id width
   localparam int TL_SZW = 4;   // size field width

   typedef enum logic [2:0] {
      PutFullData    = 3'd0,
      PutPartialData = 3'd1,
      Get            = 3'd4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'd0,
      AccessAckData = 3'd1
   } tl_d_op_e;

   // Byte lanes a naturally aligned access of 2**size bytes may touch.
   // Sizes above a word return no lanes; such requests are rejected anyway.
   function automatic logic [3:0] lane_mask(input logic [TL_SZW-1:0] size,
                                            input logic [1:0]        addr_lo);
      logic [3:0] lanes;
      case (size)
         4'd0:    lanes = 4'b0001 << addr_lo;
         4'd1:    lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
         4'd2:    lanes = 4'hF;
         default: lanes = 4'h0;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/tlul_sram_mem.sv
// Purpose: word-addressed 32-bit memory, byte-enabled write, registered read.
// Latency: write and read both take effect at the enabling clock edge.
// Backpressure: none; always accepts.
// Ports: clk; we/be/wdata write strobe, byte enables and data; re read
//        strobe; addr shared word address; rdata registered read word.
module tlul_sram_mem #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Storage is deliberately not reset; contents survive a link reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/tlul_sram_responder.sv
// Purpose: TL-UL slave serving Get/Put from a local SRAM, one txn at a time.
// Latency: d_valid rises LATENCY cycles after the A handshake cycle.
// Backpressure: d_* held stable until d_ready; a_ready low from A handshake
//               until the cycle after the D handshake.
// Ports: clk, rst (async, active high); Channel A a_* in with a_ready out;
//        Channel D d_* out with d_ready in; bad_req_cnt saturating count of
//        rejected requests.
module tlul_sram_responder
   import tlul_pkg::*;
#(
   parameter int DEPTH     = 256,
   parameter int LATENCY   = 1,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [2:0]           a_opcode,
   input  logic [2:0]           a_param,
   input  logic [TL_SZW-1:0]    a_size,
   input  logic [3:0]           a_mask,
   input  logic [31:0]          a_address,
   input  logic [TL_DW-1:0]     a_data,
   input  logic [TL_AIW-1:0]    a_source,
   output logic                 d_valid,
   input  logic                 d_ready,
   output logic [2:0]           d_opcode,
   output logic [2:0]           d_param,
   output logic [TL_SZW-1:0]    d_size,
   output logic [TL_DW-1:0]     d_data,
   output logic [TL_AIW-1:0]    d_source,
   output logic [TL_DIW-1:0]    d_sink,
   output logic [ERR_CNT_W-1:0] bad_req_cnt
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

   state_e              state;
   logic [CW-1:0]       wait_cnt;
   tl_d_op_e            d_op_q;
   logic                d_data_sel;
   logic [TL_DW-1:0]    rd_word;

   logic                a_hs;
   logic                is_get, is_put;
   logic                op_ok, size_ok, align_ok, range_ok, mask_ok, req_ok;
   logic [3:0]          lanes;
   logic                unused_a_param;

   assign unused_a_param = ^a_param;

   // a_ready is a pure state decode, forced low while reset is held.
   assign a_ready = (state == ST_IDLE) && !rst;
   assign a_hs    = a_valid && a_ready;

   // ---------------- legality check ----------------
   assign is_get  = (a_opcode == Get);
   assign is_put  = (a_opcode == PutFullData) || (a_opcode == PutPartialData);
   assign op_ok   = is_get || is_put;
   assign size_ok = (a_size <= 4'd2);
   assign lanes   = lane_mask(a_size, a_address[1:0]);

   always_comb begin
      align_ok = 1'b1;
      if (a_size == 4'd1) align_ok = !a_address[0];
      if (a_size == 4'd2) align_ok = (a_address[1:0] == 2'b00);
   end

   generate
      if (AW + 2 < 32) begin : g_range
         assign range_ok = (a_address[31:AW+2] == '0);
      end else begin : g_range_full
         assign range_ok = 1'b1;
      end
   endgenerate

   // No enable outside the access lanes; a full put must cover all of them.
   assign mask_ok = ((a_mask & ~lanes) == 4'h0) &&
                    ((a_opcode != PutFullData) || (a_mask == lanes));

   assign req_ok = op_ok && size_ok && align_ok && range_ok && mask_ok;

   // ---------------- memory ----------------
   tlul_sram_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (a_hs && req_ok && is_put),
      .be    (a_mask),
      .re    (a_hs && req_ok && is_get),
      .addr  (a_address[AW+1:2]),
      .wdata (a_data),
      .rdata (rd_word)
   );

   // ---------------- protocol FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         wait_cnt    <= '0;
         d_valid     <= 1'b0;
         d_op_q      <= AccessAck;
         d_size      <= '0;
         d_source    <= '0;
         d_data_sel  <= 1'b0;
         bad_req_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (a_hs) begin
                  d_op_q     <= is_get ? AccessAckData : AccessAck;
                  d_size     <= a_size;
                  d_source   <= a_source;
                  d_data_sel <= req_ok && is_get;
                  if (!req_ok && (bad_req_cnt != {ERR_CNT_W{1'b1}}))
                     bad_req_cnt <= bad_req_cnt + 1'b1;
                  if (LATENCY > 1) begin
                     state    <= ST_WAIT;
                     wait_cnt <= CNT_LOAD;
                  end else begin
                     state    <= ST_RESP;
                     d_valid  <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt == CNT_ONE) begin
                  state   <= ST_RESP;
                  d_valid <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_RESP: begin
               if (d_ready) begin
                  state   <= ST_IDLE;
                  d_valid <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               d_valid <= 1'b0;
            end
         endcase
      end
   end

   // Read word is held in the memory's output register until the next Get,
   // so gating it with a captured select keeps d_data stable and zero for
   // acks and rejected reads.
   assign d_data   = d_data_sel ? rd_word : '0;
   assign d_opcode = d_op_q;
   assign d_param  = '0;
   assign d_sink   = '0;

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Purpose: directed bench for tlul_sram_responder (DEPTH=256, LATENCY=3).
// Latency: drives and samples on the falling edge of clk.
// Backpressure: exercises held d_ready and mid-response reset.
module tb_tlul_sram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid;
   logic        a_ready;
   logic [2:0]  a_opcode;
   logic [2:0]  a_param;
   logic [3:0]  a_size;
   logic [3:0]  a_mask;
   logic [31:0] a_address;
   logic [31:0] a_data;
   logic [2:0]  a_source;
   logic        d_valid;
   logic        d_ready;
   logic [2:0]  d_opcode;
   logic [2:0]  d_param;
   logic [3:0]  d_size;
   logic [31:0] d_data;
   logic [2:0]  d_source;
   logic [1:0]  d_sink;
   logic [7:0]  bad_req_cnt;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   tlul_sram_responder #(
      .DEPTH     (256),
      .LATENCY   (3),
      .ERR_CNT_W (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .a_valid     (a_valid),
      .a_ready     (a_ready),
      .a_opcode    (a_opcode),
      .a_param     (a_param),
      .a_size      (a_size),
      .a_mask      (a_mask),
      .a_address   (a_address),
      .a_data      (a_data),
      .a_source    (a_source),
      .d_valid     (d_valid),
      .d_ready     (d_ready),
      .d_opcode    (d_opcode),
      .d_param     (d_param),
      .d_size      (d_size),
      .d_data      (d_data),
      .d_source    (d_source),
      .d_sink      (d_sink),
      .bad_req_cnt (bad_req_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Present a request and return on the falling edge after its handshake.
   task automatic send_a(input logic [2:0] op, input logic [3:0] size, input logic [3:0] mask,
                         input logic [31:0] addr, input logic [31:0] data, input logic [2:0] src);
      int n;
      @(negedge clk);
      a_valid   = 1'b1;
      a_opcode  = op;
      a_size    = size;
      a_mask    = mask;
      a_address = addr;
      a_data    = data;
      a_source  = src;
      n = 0;
      while (!a_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!a_ready) chk("a_ready_timeout", {31'b0, a_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0;
   endtask

   // Cycles from the handshake cycle until d_valid is seen.
   task automatic wait_d(output int lat);
      lat = 1;
      while (!d_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic txn(input string tag, input logic [2:0] op, input logic [3:0] size,
                      input logic [3:0] mask, input logic [31:0] addr, input logic [31:0] data,
                      input logic [2:0] src, input int hold,
                      input logic [2:0] exp_op, input logic [31:0] exp_data);
      int lat;
      send_a(op, size, mask, addr, data, src);
      wait_d(lat);
      chk({tag, "_lat"}, 32'(lat), 32'd3);
      chk({tag, "_param"}, 32'(d_param), 32'd0);
      chk({tag, "_sink"}, 32'(d_sink), 32'd0);
      for (int i = 0; i <= hold; i++) begin
         chk({tag, "_dvalid"}, 32'(d_valid), 32'd1);
         chk({tag, "_opcode"}, 32'(d_opcode), 32'(exp_op));
         chk({tag, "_data"}, d_data, exp_data);
         chk({tag, "_source"}, 32'(d_source), 32'(src));
         chk({tag, "_size"}, 32'(d_size), 32'(size));
         chk({tag, "_aready_busy"}, 32'(a_ready), 32'd0);
         if (i != hold) @(negedge clk);
      end
      d_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d_ready = 1'b0;
      chk({tag, "_aready_after"}, 32'(a_ready), 32'd1);
      chk({tag, "_dvalid_after"}, 32'(d_valid), 32'd0);
   endtask

   initial begin
      int lat;
      rst       = 1'b1;
      a_valid   = 1'b0;
      a_opcode  = 3'd0;
      a_param   = 3'd0;
      a_size    = 4'd0;
      a_mask    = 4'd0;
      a_address = 32'd0;
      a_data    = 32'd0;
      a_source  = 3'd0;
      d_ready   = 1'b0;

      // Reset state
      #1;
      chk("rst_aready", 32'(a_ready), 32'd0);
      chk("rst_dvalid", 32'(d_valid), 32'd0);
      chk("rst_dopcode", 32'(d_opcode), 32'd0);
      chk("rst_ddata", d_data, 32'd0);
      chk("rst_dsource", 32'(d_source), 32'd0);
      chk("rst_dsize", 32'(d_size), 32'd0);
      chk("rst_badcnt", 32'(bad_req_cnt), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_aready", 32'(a_ready), 32'd1);

      // Put then Get, with 5 cycles of held-off d_ready on the put
      txn("put_full", 3'd0, 4'd2, 4'hF, 32'h10, 32'hDEADBEEF, 3'd3, 5, 3'd0, 32'h0);
      txn("get_10",   3'd4, 4'd2, 4'hF, 32'h10, 32'h0,        3'd3, 0, 3'd1, 32'hDEADBEEF);

      // Partial write of lanes 0 and 2
      txn("put_part", 3'd1, 4'd2, 4'h5, 32'h10, 32'h11223344, 3'd2, 0, 3'd0, 32'h0);
      txn("get_part", 3'd4, 4'd2, 4'hF, 32'h10, 32'h0,        3'd2, 2, 3'd1, 32'hDE22BE44);

      // Malformed requests
      txn("bad_range", 3'd4, 4'd2, 4'hF, 32'h400, 32'h0, 3'd1, 0, 3'd1, 32'h0);
      chk("badcnt_1", 32'(bad_req_cnt), 32'd1);
      txn("bad_op",    3'd3, 4'd2, 4'hF, 32'h0,   32'h0, 3'd4, 0, 3'd0, 32'h0);
      chk("badcnt_2", 32'(bad_req_cnt), 32'd2);
      txn("put_4",     3'd0, 4'd2, 4'hF, 32'h4, 32'h55667788, 3'd5, 0, 3'd0, 32'h0);
      txn("bad_mask",  3'd0, 4'd2, 4'h3, 32'h4, 32'hFFFFFFFF, 3'd5, 0, 3'd0, 32'h0);
      chk("badcnt_3", 32'(bad_req_cnt), 32'd3);
      txn("get_4",     3'd4, 4'd2, 4'hF, 32'h4, 32'h0,        3'd5, 0, 3'd1, 32'h55667788);

      // Sub-word access
      txn("put_20",    3'd0, 4'd2, 4'hF, 32'h20, 32'h00000000, 3'd7, 0, 3'd0, 32'h0);
      txn("put_byte",  3'd0, 4'd0, 4'h2, 32'h21, 32'h0000AB00, 3'd7, 0, 3'd0, 32'h0);
      txn("get_20",    3'd4, 4'd2, 4'hF, 32'h20, 32'h0,        3'd7, 0, 3'd1, 32'h0000AB00);
      txn("bad_align", 3'd1, 4'd1, 4'h6, 32'h21, 32'hFFFFFFFF, 3'd7, 0, 3'd0, 32'h0);
      chk("badcnt_4", 32'(bad_req_cnt), 32'd4);
      txn("get_20b",   3'd4, 4'd2, 4'hF, 32'h20, 32'h0,        3'd6, 0, 3'd1, 32'h0000AB00);

      // Reset while a response is pending
      send_a(3'd4, 4'd2, 4'hF, 32'h10, 32'h0, 3'd6);
      wait_d(lat);
      chk("mid_dvalid", 32'(d_valid), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_dvalid", 32'(d_valid), 32'd0);
      chk("mid_rst_aready", 32'(a_ready), 32'd0);
      chk("mid_rst_badcnt", 32'(bad_req_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_aready", 32'(a_ready), 32'd1);
      chk("post_rst_dvalid", 32'(d_valid), 32'd0);
      chk("post_rst_badcnt", 32'(bad_req_cnt), 32'd0);
      txn("get_after_rst", 3'd4, 4'd2, 4'hF, 32'h10, 32'h0, 3'd1, 0, 3'd1, 32'hDE22BE44);
      chk("final_badcnt", 32'(bad_req_cnt), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
